// File: rtl/twos_to_float_pipe_if.sv
// Stream bundle for twos_to_float_pipe: sample input side and float result side.
// slave: the converter. master: the sample source / float consumer environment.
interface twos_to_float_pipe_if #(
    parameter int IN_W   = 12,
    parameter int EXP_W  = 3,
    parameter int MANT_W = 4
);
    logic [IN_W-1:0]   in_data;
    logic              in_valid;
    logic              in_ready;
    logic              out_sign;
    logic [EXP_W-1:0]  out_exp;
    logic [MANT_W-1:0] out_mant;
    logic              out_sat;
    logic              out_valid;
    logic              out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_sign, out_exp, out_mant, out_sat, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_sign, out_exp, out_mant, out_sat, out_valid
    );
endinterface

// File: rtl/twos_to_float_pipe.sv
// Three-stage two's-complement to sign/exponent/significand converter.
//   S1: sign and magnitude (most-negative input clamps and flags saturation)
//   S2: leading-zero priority encode -> exponent
//   S3: significand extraction, optional round-half-up, renormalise/saturate
// Valid/ready on both sides; each stage loads when empty or when its successor
// loads, so bubbles collapse and a full pipe sustains one sample per clock.
// Optional feature macro: TWOS_TO_FLOAT_ROUND_EN (defined: round-half-up,
// undefined: truncation). The S3 datapath and latency are the same either way.
module twos_to_float_pipe #(
    parameter int IN_W   = 12,
    parameter int EXP_W  = 3,
    parameter int MANT_W = 4
) (
    input logic                 clk,
    input logic                 reset,
    twos_to_float_pipe_if.slave bus
);
    localparam int MAG_W = IN_W - 1;
    localparam int E_TOP = MAG_W - MANT_W;
    localparam int LZ_W  = $clog2(MAG_W + 1);
    localparam logic [EXP_W-1:0] E_TOP_V = EXP_W'(E_TOP);

`ifdef TWOS_TO_FLOAT_ROUND_EN
    localparam logic ROUND_EN = 1'b1;
`else
    localparam logic ROUND_EN = 1'b0;
`endif

    generate
        if (E_TOP < 1 || E_TOP > (2 ** EXP_W) - 1) begin : g_bad_params
            $error("twos_to_float_pipe: E_TOP = IN_W-1-MANT_W must lie in 1..2^EXP_W-1");
        end
    endgenerate

    // Stage registers
    logic              s1_valid, s1_sign, s1_sat;
    logic [MAG_W-1:0]  s1_mag;
    logic              s2_valid, s2_sign, s2_sat;
    logic [MAG_W-1:0]  s2_mag;
    logic [EXP_W-1:0]  s2_exp;
    logic              s3_valid, s3_sign, s3_sat;
    logic [EXP_W-1:0]  s3_exp;
    logic [MANT_W-1:0] s3_mant;

    // Stage load conditions, chained back from the consumer
    logic s1_load, s2_load, s3_load;
    assign s3_load = ~s3_valid | bus.out_ready;
    assign s2_load = ~s2_valid | s3_load;
    assign s1_load = ~s1_valid | s2_load;

    assign bus.in_ready  = s1_load;
    assign bus.out_valid = s3_valid;
    assign bus.out_sign  = s3_sign;
    assign bus.out_exp   = s3_exp;
    assign bus.out_mant  = s3_mant;
    assign bus.out_sat   = s3_sat;

    // S1 combinational: sign / magnitude. The low MAG_W bits of the negation
    // depend only on the low MAG_W bits of the input.
    logic             in_sign, in_min_neg;
    logic [MAG_W-1:0] neg_mag, in_mag;
    assign in_sign    = bus.in_data[IN_W-1];
    assign in_min_neg = (bus.in_data == {1'b1, {MAG_W{1'b0}}});
    assign neg_mag    = ~bus.in_data[MAG_W-1:0] + MAG_W'(1);
    assign in_mag     = in_min_neg ? '1 : (in_sign ? neg_mag : bus.in_data[MAG_W-1:0]);

    // Stage 1 register: capture sign, magnitude and clamp flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            s1_sign  <= 1'b0;
            s1_sat   <= 1'b0;
            s1_mag   <= '0;
        end else if (s1_load) begin
            s1_valid <= bus.in_valid;
            s1_sign  <= in_sign;
            s1_sat   <= in_min_neg;
            s1_mag   <= in_mag;
        end
    end

    // S2 combinational: leading-zero count (highest set bit wins) and exponent
    logic [LZ_W-1:0]  lz;
    logic [EXP_W-1:0] exp_next;
    always_comb begin
        lz = LZ_W'(MAG_W);
        for (int unsigned i = 0; i < MAG_W; i++) begin
            if (s1_mag[i]) lz = LZ_W'(MAG_W - 1 - i);
        end
        exp_next = (int'(lz) < E_TOP) ? EXP_W'(E_TOP - int'(lz)) : '0;
    end

    // Stage 2 register: carry magnitude forward with its exponent
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s2_valid <= 1'b0;
            s2_sign  <= 1'b0;
            s2_sat   <= 1'b0;
            s2_mag   <= '0;
            s2_exp   <= '0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            s2_sign  <= s1_sign;
            s2_sat   <= s1_sat;
            s2_mag   <= s1_mag;
            s2_exp   <= exp_next;
        end
    end

    // S3 combinational: significand, rounding, renormalise or saturate.
    // The round bit is always extracted; ROUND_EN only gates the increment.
    logic [MANT_W-1:0] mant_trunc, mant_next;
    logic [MANT_W:0]   mant_sum;
    logic              round_bit;
    logic [EXP_W-1:0]  exp_final;
    logic              sat_final;
    always_comb begin
        mant_trunc = MANT_W'(s2_mag >> s2_exp);
        round_bit  = (s2_exp != '0) &&
                     (((s2_mag >> (s2_exp - EXP_W'(1))) & MAG_W'(1)) != '0);
        mant_sum   = {1'b0, mant_trunc} + (MANT_W+1)'(ROUND_EN & round_bit);
        mant_next  = mant_sum[MANT_W-1:0];
        exp_final  = s2_exp;
        sat_final  = s2_sat;
        if (mant_sum[MANT_W]) begin
            if (s2_exp >= E_TOP_V) begin
                mant_next = '1;
                exp_final = E_TOP_V;
                sat_final = 1'b1;
            end else begin
                mant_next = MANT_W'(1) << (MANT_W - 1);
                exp_final = s2_exp + EXP_W'(1);
            end
        end
    end

    // Stage 3 register: the visible result, held while the consumer stalls
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s3_valid <= 1'b0;
            s3_sign  <= 1'b0;
            s3_sat   <= 1'b0;
            s3_exp   <= '0;
            s3_mant  <= '0;
        end else if (s3_load) begin
            s3_valid <= s2_valid;
            s3_sign  <= s2_sign;
            s3_sat   <= sat_final;
            s3_exp   <= exp_final;
            s3_mant  <= mant_next;
        end
    end
endmodule
